// File: rtl/tt_stim_gen.sv
// Truth-table stimulus generator: sweeps {A,B,C} through 4 or 8 patterns, holding each
// for HOLD cycles, and captures the downstream response bit for each pattern into tt.
module tt_stim_gen #(
  parameter int unsigned HOLD = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       loop,
  input  logic       abort,
  input  logic       resp,
  output logic [2:0] abc,
  output logic       pat_valid,
  output logic [2:0] step,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt
);

  // Handshake: start is a level request, accepted on any rising edge that sees it high
  // while IDLE; busy stays high from that edge until the sweep ends or is aborted.

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] step_d;
  logic       mode_q, mode_d;
  logic [7:0] tt_d;
  logic       done_d;
  logic       run_d;
  logic [2:0] abc_d;
  logic [2:0] last_step;

  function automatic logic [2:0] map_pat(input logic m, input logic [2:0] s);
    return m ? s : {s[1], s[0], 1'b0};
  endfunction

  assign last_step = mode_q ? 3'd7 : 3'd3;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    step_d  = step;
    mode_d  = mode_q;
    tt_d    = tt;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          step_d  = 3'd0;
          hcnt_d  = 8'd0;
          tt_d    = 8'd0;
          mode_d  = mode;
        end
      end
      RUN: begin
        // abort outranks a coinciding capture and the end-of-pass pulse
        if (abort) begin
          state_d = IDLE;
          step_d  = 3'd0;
          hcnt_d  = 8'd0;
        end else if (hcnt_q == HOLD_LAST) begin
          tt_d[step] = resp;
          hcnt_d     = 8'd0;
          if (step == last_step) begin
            done_d = 1'b1;
            step_d = 3'd0;
            if (!loop) state_d = IDLE;
          end else begin
            step_d = step + 3'd1;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN);
    abc_d = run_d ? map_pat(mode_d, step_d) : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hcnt_q    <= 8'd0;
      step      <= 3'd0;
      mode_q    <= 1'b0;
      tt        <= 8'd0;
      done      <= 1'b0;
      busy      <= 1'b0;
      pat_valid <= 1'b0;
      abc       <= 3'd0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      step      <= step_d;
      mode_q    <= mode_d;
      tt        <= tt_d;
      done      <= done_d;
      busy      <= run_d;
      pat_valid <= run_d;
      abc       <= abc_d;
    end
  end

endmodule

// File: tb/tb_tt_stim_gen.sv
// Bench for tt_stim_gen: directed sweeps, aborts and resets plus randomized truth tables,
// checked cycle by cycle against a pattern/time model of the sweep.
module tb_tt_stim_gen;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, mode, loop, abort, resp;
  logic [2:0] abc, step;
  logic       pat_valid, busy, done;
  logic [7:0] tt;

  int checks = 0;
  int errors = 0;

  tt_stim_gen #(.HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .loop(loop),
    .abort(abort), .resp(resp), .abc(abc), .pat_valid(pat_valid),
    .step(step), .busy(busy), .done(done), .tt(tt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {A,B,C} for pattern i as defined by the sweep mode
  function automatic logic [2:0] pat_of(input logic m, input int i);
    logic [2:0] v;
    v = 3'(i);
    return m ? v : {v[1], v[0], 1'b0};
  endfunction

  // truth table of final = (A&B)^(A&C) over the patterns of a mode
  function automatic logic [7:0] gate_tt(input logic m);
    logic [7:0] t;
    logic [2:0] p;
    t = 8'd0;
    for (int i = 0; i < (m ? 8 : 4); i++) begin
      p = pat_of(m, i);
      t[i] = (p[2] & p[1]) ^ (p[2] & p[0]);
    end
    return t;
  endfunction

  logic [7:0] exp_tt;

  // One sweep: start in mode m for 'passes' passes; resp follows 'truth' at capture edges
  // and is random noise elsewhere. abort_c / rst_c name the cycle whose closing edge aborts
  // or resets (-1 = never).
  task automatic sweep(input logic m, input int passes, input logic [7:0] truth,
                       input int abort_c, input int rst_c, input bit chk_tt);
    int n, total, idx;
    bit cap, last;
    n = m ? 8 : 4;
    total = passes * n * HOLD;
    exp_tt = 8'd0;
    start = 1'b1; mode = m; loop = (passes > 1); abort = 1'b0; resp = 1'b0;
    @(negedge clk);
    for (int c = 0; c < total; c++) begin
      idx = (c / HOLD) % n;
      check("abc",       {5'd0, abc},       {5'd0, pat_of(m, idx)});
      check("step",      {5'd0, step},      8'(idx));
      check("pat_valid", {7'd0, pat_valid}, 8'd1);
      check("busy",      {7'd0, busy},      8'd1);
      check("done_run",  {7'd0, done},      {7'd0, (c > 0) && (c % (n * HOLD) == 0)});
      check("tt_run",    tt,                exp_tt);
      cap  = (c % HOLD) == HOLD - 1;
      last = (c % (n * HOLD)) == n * HOLD - 1;
      resp  = cap ? truth[idx] : 1'($urandom);
      loop  = last ? ((c / (n * HOLD)) < passes - 1) : 1'($urandom);
      start = (c == total - 1) ? 1'b0 : 1'($urandom);
      mode  = 1'($urandom);
      if (c == abort_c) abort = 1'b1;
      if (c == rst_c) rst_n = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (c == abort_c) begin
        abort = 1'b0;
        check("abort_busy", {7'd0, busy},      8'd0);
        check("abort_pv",   {7'd0, pat_valid}, 8'd0);
        check("abort_abc",  {5'd0, abc},       8'd0);
        check("abort_done", {7'd0, done},      8'd0);
        if (chk_tt) check("abort_tt", tt, exp_tt);
        @(negedge clk);
        check("abort_idle", {7'd0, busy}, 8'd0);
        check("abort_done2", {7'd0, done}, 8'd0);
        return;
      end
      if (c == rst_c) begin
        rst_n = 1'b1;
        check("rst_abc",  {5'd0, abc},       8'd0);
        check("rst_pv",   {7'd0, pat_valid}, 8'd0);
        check("rst_step", {5'd0, step},      8'd0);
        check("rst_busy", {7'd0, busy},      8'd0);
        check("rst_done", {7'd0, done},      8'd0);
        check("rst_tt",   tt,                8'd0);
        return;
      end
      if (cap) exp_tt[idx] = truth[idx];
    end
    check("end_busy", {7'd0, busy},      8'd0);
    check("end_pv",   {7'd0, pat_valid}, 8'd0);
    check("end_abc",  {5'd0, abc},       8'd0);
    check("end_done", {7'd0, done},      8'd1);
    check("end_tt",   tt,                exp_tt);
    @(negedge clk);
    check("idle_done", {7'd0, done}, 8'd0);
    check("idle_busy", {7'd0, busy}, 8'd0);
    check("idle_tt",   tt,           exp_tt);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; loop = 1'b0; abort = 1'b0; resp = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_abc",  {5'd0, abc},       8'd0);
    check("reset_pv",   {7'd0, pat_valid}, 8'd0);
    check("reset_step", {5'd0, step},      8'd0);
    check("reset_busy", {7'd0, busy},      8'd0);
    check("reset_done", {7'd0, done},      8'd0);
    check("reset_tt",   tt,                8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", {7'd0, busy}, 8'd0);

    sweep(1'b1, 1, gate_tt(1'b1), -1, -1, 1'b1);
    check("tt_mode1", tt, 8'h60);
    sweep(1'b0, 1, gate_tt(1'b0), -1, -1, 1'b1);
    check("tt_mode0", tt, 8'h08);
    sweep(1'b1, 3, gate_tt(1'b1), -1, -1, 1'b1);
    check("tt_loop", tt, 8'h60);
    sweep(1'b1, 1, gate_tt(1'b1), 5 * HOLD + 1, -1, 1'b1);
    check("tt_abort_hi", {5'd0, tt[7:5]}, 8'd0);
    sweep(1'b0, 2, 8'($urandom), 4 * HOLD - 1, -1, 1'b0);
    sweep(1'b1, 1, gate_tt(1'b1), -1, 3 * HOLD + 2, 1'b1);
    sweep(1'b1, 1, gate_tt(1'b1), -1, -1, 1'b1);
    check("tt_after_rst", tt, 8'h60);

    for (int r = 0; r < 6; r++) begin
      sweep(1'($urandom), int'($urandom_range(1, 2)), 8'($urandom), -1, -1, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
